rggen_apb_timeout_adapter: RTL and testbench
============================================

RGGEN_APB_TIMEOUT_ADAPTER -- requirements
Module: rggen_apb_timeout_adapter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: APB/bus address width in bits.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: data width in bits; strobe width is BUS_WIDTH/8.
REQ-003 SHALL have parameter REGISTERS, default 1: number of register_if entries.
REQ-004 SHALL have parameter ERROR_STATUS, type rggen_status, default RGGEN_OKAY: status returned for unmapped addresses.
REQ-005 SHALL have parameter ERROR_DATA, default '0: read data returned for unmapped addresses, timeouts and rejects.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 16: wait-cycle limit; 0 disables the timeout.
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-008 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port apb_if, rggen_apb_if.slave: APB4 completer, including pprot and pstrb.
REQ-010 SHALL have port register_if[REGISTERS], rggen_register_if.host: register-side connections.
REQ-011 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when an access times out.

Function
REQ-012 SHALL implement a state machine with states IDLE, BUSY and RESP.
REQ-013 SHALL assert bus_if.valid when psel=1 and the state is IDLE or BUSY; address, write, write_data and strobe SHALL pass straight through from APB.
REQ-014 IDLE with psel=1: ready=1 goes to RESP; ready=0 goes to BUSY with the wait counter cleared to 0.
REQ-015 BUSY: ready=1 goes to RESP with read_data and status[1] captured; otherwise the counter increments by 1.
REQ-016 BUSY with counter = TIMEOUT_CYCLES-1 and ready=0 (TIMEOUT_CYCLES>0): go to RESP, prdata=ERROR_DATA, pslverr=1, o_timeout=1 for that cycle.
REQ-017 If ready and the timeout coincide in the same cycle, ready SHALL win: normal response, no o_timeout.
REQ-018 pready SHALL be a register equal to (state==RESP): exactly one cycle high, one cycle after ready or timeout; RESP always returns to IDLE.
REQ-019 Minimum access SHALL complete with pready in the cycle after the setup cycle (ready in the same cycle as psel).
REQ-020 psel deasserting in BUSY (protocol violation) SHALL return to IDLE with no pready and no o_timeout.
REQ-021 prdata and pslverr SHALL be updated only on the transition into RESP and otherwise held.
REQ-022 The wait counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits, at least 1, and SHALL saturate rather than wrap.

Reset
REQ-023 While i_rst_n=0: state=IDLE, counter=0, pready=0, pslverr=0, prdata=0, o_timeout=0.
REQ-024 Reset asserted mid-access SHALL abort the access immediately with no response; the first post-reset access SHALL behave as a fresh access.

Configuration
REQ-025 Macro RGGEN_APB_PPROT_CHECK_EN defined: an IDLE access with pprot[0]=0 SHALL not assert bus_if.valid and SHALL go straight to RESP with pslverr=1 and prdata=ERROR_DATA.
REQ-026 Macro RGGEN_APB_PPROT_CHECK_EN undefined: pprot SHALL be ignored and all accesses handled per REQ-013..REQ-022.

Structure
REQ-027 rggen_status and the state enum type SHALL be defined in rggen_rtl_pkg; the counter width SHALL be a localparam.
REQ-028 Decode, strobe handling and error status SHALL be delegated to one instance of sub-module rggen_adapter_common, with ERROR_STATUS/ERROR_DATA passed through; the interconnect SHALL be an internal rggen_bus_if #(ADDRESS_WIDTH, BUS_WIDTH).

Verification
REQ-029 Write 0x12345678 to register 0, ready in cycle 0 -> pready in cycle 1, pslverr=0; readback returns 0x12345678.
REQ-030 Register stalls 3 cycles, TIMEOUT_CYCLES=16 -> pready one cycle after ready, o_timeout never asserted.
REQ-031 Register never ready, TIMEOUT_CYCLES=4 -> o_timeout pulse after 4 BUSY cycles, then pready with pslverr=1 and prdata=ERROR_DATA.
REQ-032 Ready on the exact timeout cycle -> normal data, pslverr=0, o_timeout=0.
REQ-033 i_rst_n pulsed low during BUSY -> pready/pslverr/prdata/o_timeout=0 at once, and the next access completes normally.
REQ-034 With RGGEN_APB_PPROT_CHECK_EN, read with pprot=3'b000 -> bus_if.valid never high, pready next cycle with pslverr=1; pprot=3'b001 -> normal access.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the RgGen APB timeout adapter slice: bus status codes,
// adapter FSM states and the wait-counter width helper.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    RGGEN_APB_IDLE = 2'd0,
    RGGEN_APB_BUSY = 2'd1,
    RGGEN_APB_RESP = 2'd2
  } rggen_apb_state;

  // A timeout of zero still needs a one-bit counter so the datapath stays legal.
  function automatic int rggen_counter_width(input int cycles);
    int width;
    width = $clog2(cycles + 1);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/rggen_apb_timeout_adapter_if.sv
// Bus interfaces of the adapter slice: APB4 completer side, internal
// adapter bus and the per-register host connection.
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]               pprot;
  logic                     pwrite;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );
  modport slave (
    input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );
endinterface

interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                       valid;
  logic                       write;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [BUS_WIDTH/8-1:0]     strobe;
  logic                       ready;
  rggen_rtl_pkg::rggen_status status;
  logic [BUS_WIDTH-1:0]       read_data;

  modport master (
    output valid, write, address, write_data, strobe,
    input  ready, status, read_data
  );
  modport slave (
    input  valid, write, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                       valid;
  logic                       write;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [BUS_WIDTH-1:0]       strobe;
  logic                       active;
  logic                       ready;
  rggen_rtl_pkg::rggen_status status;
  logic [BUS_WIDTH-1:0]       read_data;

  modport host (
    output valid, write, address, write_data, strobe,
    input  active, ready, status, read_data
  );
  modport register (
    input  valid, write, address, write_data, strobe,
    output active, ready, status, read_data
  );
endinterface

// File: rtl/rggen_adapter_common.sv
// Fans the adapter bus out to all registers, expands byte strobes to a bit
// mask and answers unmapped addresses at once with the error status/data.
module rggen_adapter_common
  import rggen_rtl_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH = 8,
  parameter int                   BUS_WIDTH     = 32,
  parameter int                   REGISTERS     = 1,
  parameter rggen_status          ERROR_STATUS  = RGGEN_OKAY,
  parameter logic [BUS_WIDTH-1:0] ERROR_DATA    = '0
)(
  rggen_bus_if.slave     bus_if,
  rggen_register_if.host register_if[REGISTERS]
);
  logic [BUS_WIDTH-1:0]                  strobe_mask_s;
  logic [REGISTERS-1:0]                  active_v_s;
  logic [REGISTERS-1:0]                  ready_v_s;
  logic [REGISTERS-1:0][1:0]             status_v_s;
  logic [REGISTERS-1:0][BUS_WIDTH-1:0]   read_data_v_s;
  logic                                  ready_s;
  logic [1:0]                            status_s;
  logic [BUS_WIDTH-1:0]                  read_data_s;
  logic [1:0]                            status_or_s;
  logic [BUS_WIDTH-1:0]                  read_data_or_s;

  // Byte strobe to per-bit write mask
  always_comb begin
    strobe_mask_s = '0;
    for (int b = 0; b < BUS_WIDTH / 8; b++) begin
      strobe_mask_s[8*b +: 8] = {8{bus_if.strobe[b]}};
    end
  end

  for (genvar i = 0; i < REGISTERS; i++) begin : g_register
    assign register_if[i].valid      = bus_if.valid;
    assign register_if[i].write      = bus_if.write;
    assign register_if[i].address    = bus_if.address;
    assign register_if[i].write_data = bus_if.write_data;
    assign register_if[i].strobe     = strobe_mask_s;
    assign active_v_s[i]             = register_if[i].active;
    assign ready_v_s[i]              = register_if[i].ready;
    assign status_v_s[i]             = register_if[i].status;
    assign read_data_v_s[i]          = register_if[i].read_data;
  end

  // Response select: at most one register decodes the address; none means error
  always_comb begin
    status_or_s    = 2'b00;
    read_data_or_s = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      status_or_s    = status_or_s | (status_v_s[i] & {2{active_v_s[i]}});
      read_data_or_s = read_data_or_s | (read_data_v_s[i] & {BUS_WIDTH{active_v_s[i]}});
    end
    if (|active_v_s) begin
      ready_s     = |(active_v_s & ready_v_s);
      status_s    = status_or_s;
      read_data_s = read_data_or_s;
    end else begin
      ready_s     = 1'b1;
      status_s    = ERROR_STATUS;
      read_data_s = ERROR_DATA;
    end
  end

  assign bus_if.ready     = ready_s;
  assign bus_if.status    = rggen_status'(status_s);
  assign bus_if.read_data = read_data_s;

endmodule

// File: rtl/rggen_apb_timeout_adapter.sv
// APB4 completer for RgGen register blocks with a bounded wait timeout.
// Build option: RGGEN_APB_PPROT_CHECK_EN rejects accesses with pprot[0]=0.
module rggen_apb_timeout_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH  = 8,
  parameter int                   BUS_WIDTH      = 32,
  parameter int                   REGISTERS      = 1,
  parameter rggen_status          ERROR_STATUS   = RGGEN_OKAY,
  parameter logic [BUS_WIDTH-1:0] ERROR_DATA     = '0,
  parameter int                   TIMEOUT_CYCLES = 16
)(
  input  logic           i_clk,
  input  logic           i_rst_n,
  rggen_apb_if.slave     apb_if,
  rggen_register_if.host register_if[REGISTERS],
  output logic           o_timeout
);
  localparam int                     COUNT_WIDTH = rggen_counter_width(TIMEOUT_CYCLES);
  localparam bit                     TIMEOUT_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST  = COUNT_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;

  rggen_bus_if #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .BUS_WIDTH(BUS_WIDTH)) bus_if ();

  rggen_apb_state         state_r;
  rggen_apb_state         next_state_s;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [COUNT_WIDTH-1:0] count_next_s;
  logic                   pready_r;
  logic                   pslverr_r;
  logic [BUS_WIDTH-1:0]   prdata_r;
  logic                   valid_s;
  logic                   reject_s;
  logic                   timeout_hit_s;
  logic                   capture_s;
  logic                   pslverr_next_s;
  logic [BUS_WIDTH-1:0]   prdata_next_s;
  logic                   unused_s;

`ifdef RGGEN_APB_PPROT_CHECK_EN
  assign reject_s = apb_if.psel && !apb_if.pprot[0] && (state_r == RGGEN_APB_IDLE);
`else
  assign reject_s = 1'b0;
`endif

  // Ready is excluded here so a response arriving on the last wait cycle wins.
  assign timeout_hit_s = TIMEOUT_EN && (state_r == RGGEN_APB_BUSY) && apb_if.psel &&
                         !bus_if.ready && (count_r == COUNT_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= RGGEN_APB_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = RGGEN_APB_IDLE;
    case (state_r)
      RGGEN_APB_IDLE: begin
        if (reject_s || (apb_if.psel && bus_if.ready)) next_state_s = RGGEN_APB_RESP;
        else if (apb_if.psel)                          next_state_s = RGGEN_APB_BUSY;
        else                                           next_state_s = RGGEN_APB_IDLE;
      end
      RGGEN_APB_BUSY: begin
        if (!apb_if.psel)                        next_state_s = RGGEN_APB_IDLE;
        else if (bus_if.ready || timeout_hit_s)  next_state_s = RGGEN_APB_RESP;
        else                                     next_state_s = RGGEN_APB_BUSY;
      end
      default: next_state_s = RGGEN_APB_IDLE;
    endcase
  end

  // Outputs: bus request, wait counter update and response capture values
  always_comb begin
    valid_s      = 1'b0;
    count_next_s = '0;
    case (state_r)
      RGGEN_APB_IDLE: valid_s = apb_if.psel && !reject_s;
      RGGEN_APB_BUSY: begin
        valid_s      = apb_if.psel;
        count_next_s = (count_r == COUNT_MAX) ? count_r : count_r + COUNT_WIDTH'(1);
      end
      default: valid_s = 1'b0;
    endcase
    capture_s = (next_state_s == RGGEN_APB_RESP);
    if (reject_s || timeout_hit_s) begin
      prdata_next_s  = ERROR_DATA;
      pslverr_next_s = 1'b1;
    end else begin
      prdata_next_s  = bus_if.read_data;
      pslverr_next_s = bus_if.status[1];
    end
  end

  // Response registers and wait counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r   <= '0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= '0;
    end else begin
      count_r  <= count_next_s;
      pready_r <= capture_s;
      if (capture_s) begin
        pslverr_r <= pslverr_next_s;
        prdata_r  <= prdata_next_s;
      end
    end
  end

  assign bus_if.valid      = valid_s;
  assign bus_if.write      = apb_if.pwrite;
  assign bus_if.address    = apb_if.paddr;
  assign bus_if.write_data = apb_if.pwdata;
  assign bus_if.strobe     = apb_if.pstrb;

  assign apb_if.pready  = pready_r;
  assign apb_if.prdata  = prdata_r;
  assign apb_if.pslverr = pslverr_r;
  assign o_timeout      = timeout_hit_s;

  assign unused_s = ^{apb_if.penable, apb_if.pprot, bus_if.status[0]};

  rggen_adapter_common #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .BUS_WIDTH     (BUS_WIDTH),
    .REGISTERS     (REGISTERS),
    .ERROR_STATUS  (ERROR_STATUS),
    .ERROR_DATA    (ERROR_DATA)
  ) u_common (
    .bus_if      (bus_if),
    .register_if (register_if)
  );

endmodule

// File: tb/tb_rggen_apb_timeout_adapter.sv
// Scoreboard bench for rggen_apb_timeout_adapter: two behavioural registers
// with programmable stall, directed corner cases plus randomized accesses.
module tb_rggen_apb_timeout_adapter;
  import rggen_rtl_pkg::*;

  localparam int          AW       = 8;
  localparam int          BW       = 32;
  localparam int          NREG     = 2;
  localparam int          T        = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
`ifdef RGGEN_APB_PPROT_CHECK_EN
  localparam bit PPROT_CHECK = 1'b1;
`else
  localparam bit PPROT_CHECK = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          latency;
    int          tmo;
    int          valid_cycles;
    int          start;
  } exp_t;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  logic o_timeout;

  always #5 i_clk = ~i_clk;

  rggen_apb_if      #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) apb ();
  rggen_register_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) reg_if [NREG] ();

  rggen_apb_timeout_adapter #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .REGISTERS      (NREG),
    .ERROR_STATUS   (RGGEN_SLAVE_ERROR),
    .ERROR_DATA     (ERR_DATA),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .apb_if      (apb),
    .register_if (reg_if),
    .o_timeout   (o_timeout)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ncyc     = 0;
  int          tmo_seen = 0;
  int          tmo_last = 0;
  int          valid_seen = 0;
  int          stall_cycles = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mem [NREG] = '{default: 32'h0};
  logic [NREG-1:0] reg_valid_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register models: register gi lives at byte address 4*gi, ready after stall_cycles waits
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [31:0] storage = 32'h0;
    int          wcnt    = 0;
    assign reg_valid_v[gi]      = reg_if[gi].valid;
    assign reg_if[gi].active    = reg_if[gi].valid && (reg_if[gi].address == AW'(gi * 4));
    assign reg_if[gi].ready     = reg_if[gi].active && (wcnt >= stall_cycles);
    assign reg_if[gi].status    = RGGEN_OKAY;
    assign reg_if[gi].read_data = reg_if[gi].write ? 32'h0 : storage;
    always @(posedge i_clk) begin
      if (reg_if[gi].active && !reg_if[gi].ready) wcnt <= wcnt + 1;
      else                                        wcnt <= 0;
      if (reg_if[gi].active && reg_if[gi].ready && reg_if[gi].write)
        storage <= (storage & ~reg_if[gi].strobe) | (reg_if[gi].write_data & reg_if[gi].strobe);
    end
  end

  // Monitor: pops the scoreboard on every pready
  always @(negedge i_clk) begin
    ncyc++;
    if (o_timeout)    begin tmo_seen++; tmo_last = ncyc; end
    if (|reg_valid_v) valid_seen++;
    if (apb.pready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pready", 32'h1, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("prdata", apb.prdata, mon_e.data);
        check("pslverr", {31'h0, apb.pslverr}, {31'h0, mon_e.err});
        check("latency", 32'(ncyc - mon_e.start), 32'(mon_e.latency));
        check("timeout_count", 32'(tmo_seen), 32'(mon_e.tmo));
        check("valid_cycles", 32'(valid_seen), 32'(mon_e.valid_cycles));
        if (mon_e.tmo != 0) check("timeout_cycle", 32'(tmo_last), 32'(ncyc - 1));
      end
      tmo_seen   = 0;
      valid_seen = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
    end
  endtask

  task automatic do_access(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int stall);
    exp_t e;
    bit   mapped;
    bit   got;
    int   idx;
    mapped         = (addr == 8'h00) || (addr == 8'h04);
    idx            = int'(addr[7:2]) % NREG;
    e.data         = ERR_DATA;
    e.err          = 1'b1;
    e.tmo          = 0;
    if (PPROT_CHECK && !prot[0]) begin
      e.latency = 1; e.valid_cycles = 0;
    end else if (!mapped) begin
      e.latency = 1; e.valid_cycles = 1;
    end else if (stall > T) begin
      e.latency = T + 1; e.valid_cycles = T + 1; e.tmo = 1;
    end else begin
      e.latency = stall + 1; e.valid_cycles = stall + 1; e.err = 1'b0;
      e.data    = wr ? 32'h0 : mem[idx];
      if (wr) for (int b = 0; b < 4; b++) if (strb[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    stall_cycles = stall;
    @(posedge i_clk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.paddr   = addr;
    apb.pwrite  = wr;
    apb.pwdata  = wdata;
    apb.pstrb   = wr ? strb : 4'h0;
    apb.pprot   = prot;
    e.start     = ncyc + 1;
    sb_q.push_back(e);
    @(posedge i_clk); #1;
    apb.penable = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge i_clk);
      got = apb.pready;
    end
    if (!got) begin
      check("pready_wait", 32'h0, 32'h1);
      sb_q.delete();
    end
  endtask

  // Start a never-ready access and abandon it two cycles into the wait
  task automatic abandon_access(input bit by_reset);
    stall_cycles = 255;
    @(posedge i_clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.paddr = 8'h00; apb.pwrite = 1'b0; apb.pprot = 3'b001;
    @(posedge i_clk); #1;
    apb.penable = 1'b1;
    @(posedge i_clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
    if (by_reset) begin
      i_rst_n = 1'b0;
      #1;
      check("abort_pready", {31'h0, apb.pready}, 32'h0);
      check("abort_pslverr", {31'h0, apb.pslverr}, 32'h0);
      check("abort_prdata", apb.prdata, 32'h0);
      check("abort_timeout", {31'h0, o_timeout}, 32'h0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
    end else begin
      repeat (8) @(posedge i_clk);
      #1;
      check("drop_no_timeout", 32'(tmo_seen), 32'h0);
    end
    tmo_seen   = 0;
    valid_seen = 0;
  endtask

  initial begin
    int stall_tab [8];
    logic [7:0] addr_tab [3];
    stall_tab = '{0, 1, 2, 3, 4, 5, 7, 255};
    addr_tab  = '{8'h00, 8'h04, 8'h08};
    apb.psel = 1'b0; apb.penable = 1'b0; apb.paddr = 8'h00; apb.pwrite = 1'b0;
    apb.pwdata = 32'h0; apb.pstrb = 4'h0; apb.pprot = 3'b000;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_pready", {31'h0, apb.pready}, 32'h0);
    check("reset_pslverr", {31'h0, apb.pslverr}, 32'h0);
    check("reset_prdata", apb.prdata, 32'h0);
    check("reset_timeout", {31'h0, o_timeout}, 32'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    idle(2);

    do_access(1'b1, 8'h00, 32'h1234_5678, 4'hF, 3'b001, 0);
    do_access(1'b0, 8'h00, 32'h0, 4'h0, 3'b001, 0);
    idle(1);
    do_access(1'b0, 8'h00, 32'h0, 4'h0, 3'b001, 3);
    do_access(1'b1, 8'h04, 32'hA5A5_5A5A, 4'hF, 3'b001, T);
    do_access(1'b0, 8'h04, 32'h0, 4'h0, 3'b001, T);
    do_access(1'b0, 8'h00, 32'h0, 4'h0, 3'b001, 255);
    abandon_access(1'b1);
    idle(1);
    do_access(1'b0, 8'h00, 32'h0, 4'h0, 3'b001, 0);
    idle(1);
    abandon_access(1'b0);
    do_access(1'b0, 8'h08, 32'h0, 4'h0, 3'b001, 0);
    do_access(1'b0, 8'h00, 32'h0, 4'h0, 3'b000, 0);
    do_access(1'b0, 8'h00, 32'h0, 4'h0, 3'b001, 0);
    idle(2);

    for (int n = 0; n < 80; n++) begin
      do_access(1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 2)], $urandom,
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                stall_tab[$urandom_range(0, 7)]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    check("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
